// File: rtl/io_uart_tx_if.sv
// IO bus bundle between the core's IO port and the UART transmitter.
// Protocol: a write is a single-cycle strobe (IO_memWr) qualified by a full
// 32-bit address match and is always accepted, so there is no valid/ready
// back-pressure. Reads carry no strobe: IO_memRData follows IO_memAddr
// combinationally from registered state.
interface io_uart_tx_if;
  logic [31:0] IO_memAddr;
  logic [31:0] IO_memWData;
  logic        IO_memWr;
  logic [31:0] IO_memRData;

  modport master (
    output IO_memAddr,
    output IO_memWData,
    output IO_memWr,
    input  IO_memRData
  );

  modport slave (
    input  IO_memAddr,
    input  IO_memWData,
    input  IO_memWr,
    output IO_memRData
  );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to the data register fill a
// circular byte FIFO, a baud-timed FSM shifts each byte out LSB first, and a
// status register reports busy/full/overflow/count.
module io_uart_tx #(
  parameter int unsigned BAUD_DIV    = 868,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] ADDR_DATA   = 32'h0000_0008,
  parameter logic [31:0] ADDR_STATUS = 32'h0000_0010
) (
  input  logic         clk_i,
  input  logic         reset_i,
  io_uart_tx_if.slave  io,
  output logic         tx_o,
  output logic         txBusy_o,
  output logic [1:0]   dbg_state_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic wr_data, wr_status, fifo_full, fifo_empty, push, pop, baud_done, busy;
  logic wdata_unused;

  // Only the low byte of a data store is transmitted.
  assign wdata_unused = ^io.IO_memWData[31:8];

  assign wr_data    = io.IO_memWr && (io.IO_memAddr == ADDR_DATA);
  assign wr_status  = io.IO_memWr && (io.IO_memAddr == ADDR_STATUS);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = wr_data && !fifo_full;
  assign baud_done  = (baud_q == '0);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // Transmit FSM next state: pops the FIFO head at frame start and chains
  // frames from STOP directly into START so consecutive bytes have no gap.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_LOAD;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = BAUD_LOAD;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = BAUD_LOAD;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping and sticky overflow; a store into a full FIFO is dropped
  // even when the FSM pops on the same edge.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_data && fifo_full) ovf_d = 1'b1;
    if (wr_status)            ovf_d = 1'b0;
  end

  // Transmit FSM registers; reset parks the line at the idle level at once.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // FIFO pointer, count and overflow registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= io.IO_memWData[7:0];
  end

  // Status read path, combinational from registered state.
  always_comb begin
    io.IO_memRData = 32'h0;
    if (io.IO_memAddr == ADDR_STATUS) begin
      io.IO_memRData = {16'h0, 8'(count_q), 5'h0, ovf_q, fifo_full, busy};
    end
  end

  assign tx_o        = tx_q;
  assign txBusy_o    = busy;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a frame-level reference model (byte queue plus a
// position-within-frame counter) predicts tx, busy and status every cycle;
// directed sequences add literal expectations for waveform, latency, overflow
// and asynchronous reset.
module tb_io_uart_tx;

  localparam int          B      = 4;
  localparam int          D      = 16;
  localparam int          FRAME  = 10 * B;
  localparam logic [31:0] A_DATA = 32'h0000_0008;
  localparam logic [31:0] A_STAT = 32'h0000_0010;

  // ---------------- clock / reset ----------------
  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b0;
  logic       tx_o;
  logic       txBusy_o;
  logic [1:0] dbg_state_o;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D),
    .ADDR_DATA  (A_DATA),
    .ADDR_STATUS(A_STAT)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .io         (bus),
    .tx_o       (tx_o),
    .txBusy_o   (txBusy_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // exp_q holds accepted-but-unsent bytes; t_m is the cycle position inside
  // the frame on the line (-1 when the line is idle).
  logic [7:0] exp_q[$];
  int         t_m   = -1;
  logic [7:0] cur_m = 8'h00;
  logic       ovf_m = 1'b0;

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      exp_q.delete();
      t_m   = -1;
      ovf_m = 1'b0;
    end else begin
      int sz;
      bit start;
      sz    = exp_q.size();
      start = 1'b0;
      if (t_m < 0) begin
        if (sz > 0) start = 1'b1;
      end else if (t_m == FRAME - 1) begin
        if (sz > 0) start = 1'b1;
        else        t_m = -1;
      end else begin
        t_m = t_m + 1;
      end
      if (start) begin
        cur_m = exp_q.pop_front();
        t_m   = 0;
      end
      if (bus.IO_memWr && bus.IO_memAddr == A_DATA) begin
        if (sz < D) exp_q.push_back(bus.IO_memWData[7:0]);
        else        ovf_m = 1'b1;
      end
      if (bus.IO_memWr && bus.IO_memAddr == A_STAT) ovf_m = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int         b;
    logic [7:0] s;
    if (t_m < 0) return 1'b1;
    b = t_m / B;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    s = cur_m >> (b - 1);
    return s[0];
  endfunction

  function automatic logic exp_busy();
    return (t_m >= 0) || (exp_q.size() > 0);
  endfunction

  function automatic logic [31:0] exp_status();
    int sz;
    sz = exp_q.size();
    return {16'h0, 8'(sz), 5'h0, ovf_m, (sz == D), exp_busy()};
  endfunction

  function automatic logic bit_of(input logic [9:0] v, input int k);
    logic [9:0] s;
    s = v >> k;
    return s[0];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: the inputs already on the bus are sampled at the rising edge,
  // outputs are compared against the model on the following falling edge.
  task automatic step();
    @(negedge clk_i);
    chk("model_tx", 32'(tx_o), 32'(exp_tx()));
    chk("model_busy", 32'(txBusy_o), 32'(exp_busy()));
    chk("model_rdata", bus.IO_memRData,
        (bus.IO_memAddr == A_STAT) ? exp_status() : 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.IO_memWr    = wr;
    bus.IO_memAddr  = addr;
    bus.IO_memWData = data;
    step();
  endtask

  task automatic idle(input int n);
    bus.IO_memWr   = 1'b0;
    bus.IO_memAddr = A_STAT;
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] pat;
    bus.IO_memWr    = 1'b0;
    bus.IO_memAddr  = A_STAT;
    bus.IO_memWData = 32'h0;
    reset_i         = 1'b0;

    // Reset
    repeat (3) step();
    reset_i = 1'b1;
    idle(2);
    chk("reset_tx", 32'(tx_o), 32'h1);
    chk("reset_busy", 32'(txBusy_o), 32'h0);
    chk("reset_status", bus.IO_memRData, 32'h0);

    // Single byte 0x55: start bit 1 cycle after the write, LSB first.
    pat = 10'h2AA;
    drive(1'b1, A_DATA, 32'hFFFF_FF55);
    chk("s55_latency_tx", 32'(tx_o), 32'h1);
    bus.IO_memWr   = 1'b0;
    bus.IO_memAddr = A_STAT;
    #1;
    chk("s55_count1", bus.IO_memRData, 32'h0000_0101);
    for (int i = 0; i < FRAME; i++) begin
      step();
      chk("s55_wave", 32'(tx_o), 32'(bit_of(pat, i / B)));
    end
    chk("s55_busy_last", 32'(txBusy_o), 32'h1);
    step();
    chk("s55_busy_drop", 32'(txBusy_o), 32'h0);
    chk("s55_idle_tx", 32'(tx_o), 32'h1);
    idle(5);

    // Back-to-back 0xA5, 0x0F: second start bit exactly one frame later.
    drive(1'b1, A_DATA, 32'h0000_00A5);
    drive(1'b1, A_DATA, 32'h0000_000F);
    chk("b2b_start1", 32'(tx_o), 32'h0);
    bus.IO_memWr   = 1'b0;
    bus.IO_memAddr = A_STAT;
    for (int j = 1; j < FRAME; j++) step();
    chk("b2b_stop1", 32'(tx_o), 32'h1);
    step();
    chk("b2b_start2", 32'(tx_o), 32'h0);
    idle(FRAME + 5);
    chk("b2b_done", 32'(txBusy_o), 32'h0);

    // Overflow: 18 consecutive stores into a 16-entry FIFO.
    for (int k = 0; k < 18; k++) drive(1'b1, A_DATA, $urandom());
    bus.IO_memWr   = 1'b0;
    bus.IO_memAddr = A_STAT;
    #1;
    chk("ovf_status", bus.IO_memRData, 32'h0000_1007);
    drive(1'b1, A_STAT, $urandom());
    chk("ovf_clear", bus.IO_memRData, 32'h0000_1003);
    idle(17 * FRAME + 10);
    chk("ovf_drained", 32'(txBusy_o), 32'h0);

    // Reset during data bit 3: line returns high without a clock edge.
    drive(1'b1, A_DATA, 32'h0000_0000);
    bus.IO_memWr   = 1'b0;
    bus.IO_memAddr = A_STAT;
    repeat (18) step();
    chk("rst_mid_bit3", 32'(tx_o), 32'h0);
    #2 reset_i = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx_o), 32'h1);
    chk("rst_async_busy", 32'(txBusy_o), 32'h0);
    chk("rst_async_status", bus.IO_memRData, 32'h0);
    repeat (2) step();
    reset_i = 1'b1;
    idle(FRAME + 20);
    chk("rst_no_frame", 32'(tx_o), 32'h1);
    chk("rst_no_busy", 32'(txBusy_o), 32'h0);

    // Randomized traffic: alternating fill and drain phases.
    for (int c = 0; c < 3000; c++) begin
      logic        wr;
      logic [31:0] addr;
      int          sel;
      if (((c / 400) % 2) == 0) wr = ($urandom_range(0, 2) == 0);
      else                      wr = ($urandom_range(0, 19) == 0);
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      addr = A_DATA;
      else if (sel <= 7) addr = A_STAT;
      else if (sel == 8) addr = 32'h1000_0008;
      else               addr = $urandom();
      drive(wr, addr, $urandom());
    end
    idle(17 * FRAME + 10);
    chk("rand_drained", 32'(txBusy_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
